// File: rtl/if_stage_pkg.sv
// Pipeline constants shared by the instruction-fetch stage and its next-PC logic.
// Holds the bubble and reset words, MIPS opcode/funct codes and the fetch-stage enums.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int          IADDR_W  = 30;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JR  = 2'd3
    } next_pc_sel_e;

    // What the fetch stage does to its state on the coming clock edge.
    typedef enum logic [2:0] {
        ACT_FREEZE     = 3'd0,
        ACT_HOLD       = 3'd1,
        ACT_FLUSH_WAIT = 3'd2,
        ACT_FLUSH_GO   = 3'd3,
        ACT_WAIT       = 3'd4,
        ACT_DISCARD    = 3'd5,
        ACT_ADVANCE    = 3'd6
    } fetch_action_e;

endpackage

// File: rtl/if_stage_if.sv
// I-cache request/response bus between the fetch stage (master) and the cache (slave).
interface if_stage_if;
    import if_stage_pkg::*;

    logic               ICACHE_ren;
    logic [IADDR_W-1:0] ICACHE_addr;
    logic [31:0]        ICACHE_rdata;
    logic               ICACHE_stall;

    modport master (
        output ICACHE_ren,
        output ICACHE_addr,
        input  ICACHE_rdata,
        input  ICACHE_stall
    );

    modport slave (
        input  ICACHE_ren,
        input  ICACHE_addr,
        output ICACHE_rdata,
        output ICACHE_stall
    );

endinterface

// File: rtl/if_next_pc.sv
// Combinational next-PC selection: picks sequential, branch, jump or jump-register target.
// JumpR outranks Jump, which outranks a taken branch.
module if_next_pc
    import if_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic        JumpR,
    input  logic [31:0] id_pc_plus4,
    input  logic [31:0] id_imm,
    input  logic [25:0] id_jidx,
    input  logic [31:0] id_rs_data,
    output logic        redirect,
    output logic [31:0] target
);

    next_pc_sel_e sel_s;

    // Redirect request from any control-transfer instruction in ID.
    always_comb begin
        redirect = PCSrc | Jump | JumpR;
    end

    // Resolve the select with JumpR > Jump > PCSrc.
    always_comb begin
        sel_s = SEQ;
        if (JumpR) begin
            sel_s = JR;
        end else if (Jump) begin
            sel_s = J;
        end else if (PCSrc) begin
            sel_s = BR;
        end else begin
            sel_s = SEQ;
        end
    end

    // Target address for the chosen select; branch offset arithmetic wraps mod 2^32.
    always_comb begin
        target = pc + 32'd4;
        case (sel_s)
            SEQ:     target = pc + 32'd4;
            BR:      target = id_pc_plus4 + (id_imm << 5'd2);
            J:       target = {id_pc_plus4[31:28], id_jidx, 2'b00};
            JR:      target = id_rs_data & 32'hFFFF_FFFC;
            default: target = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, I-cache request, pending-redirect tracking
// and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard_stall,
    input  logic               mem_stall,
    input  logic               PCSrc,
    input  logic               IF_Flush,
    input  logic               Jump,
    input  logic               JumpR,
    input  logic [31:0]        id_pc_plus4,
    input  logic [31:0]        id_imm,
    input  logic [25:0]        id_jidx,
    input  logic [31:0]        id_rs_data,
    if_stage_if.master         icache,
    output logic [31:0]        IF_ID_inst,
    output logic [31:0]        IF_ID_pc_plus4,
    output logic               IF_ID_valid
);
    import if_stage_pkg::*;

    logic [31:0]   pc_r;
    logic [31:0]   inst_r;
    logic [31:0]   pcp4_r;
    logic          valid_r;
    logic          pend_valid_r;
    logic [31:0]   pend_target_r;

    logic          redirect_s;
    logic [31:0]   target_s;
    logic [31:0]   pc_plus4_s;
    logic          flush_s;
    fetch_action_e action_s;

    if_next_pc u_next_pc (
        .pc          (pc_r),
        .PCSrc       (PCSrc),
        .Jump        (Jump),
        .JumpR       (JumpR),
        .id_pc_plus4 (id_pc_plus4),
        .id_imm      (id_imm),
        .id_jidx     (id_jidx),
        .id_rs_data  (id_rs_data),
        .redirect    (redirect_s),
        .target      (target_s)
    );

    // Sequential PC and the combined flush request.
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        flush_s    = IF_Flush | redirect_s;
    end

    // Decode this cycle's action; earlier conditions take precedence.
    always_comb begin
        action_s = ACT_ADVANCE;
        if (mem_stall) begin
            action_s = ACT_FREEZE;
        end else if (hazard_stall) begin
            action_s = ACT_HOLD;
        end else if (flush_s && icache.ICACHE_stall) begin
            action_s = ACT_FLUSH_WAIT;
        end else if (flush_s) begin
            action_s = ACT_FLUSH_GO;
        end else if (icache.ICACHE_stall) begin
            action_s = ACT_WAIT;
        end else if (pend_valid_r) begin
            action_s = ACT_DISCARD;
        end else begin
            action_s = ACT_ADVANCE;
        end
    end

    // PC, pending redirect and IF/ID register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inst_r        <= NOP_INST;
            pcp4_r        <= 32'h0000_0000;
            valid_r       <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
        end else begin
            case (action_s)
                ACT_FREEZE, ACT_HOLD: begin
                    pc_r <= pc_r;
                end
                // The outstanding fetch is still on the old path; remember where to go.
                ACT_FLUSH_WAIT: begin
                    pend_valid_r  <= redirect_s;
                    pend_target_r <= target_s;
                    inst_r        <= NOP_INST;
                    valid_r       <= 1'b0;
                end
                ACT_FLUSH_GO: begin
                    pc_r         <= target_s;
                    inst_r       <= NOP_INST;
                    valid_r      <= 1'b0;
                    pend_valid_r <= 1'b0;
                end
                ACT_WAIT: begin
                    inst_r  <= NOP_INST;
                    valid_r <= 1'b0;
                end
                ACT_DISCARD: begin
                    pc_r         <= pend_target_r;
                    inst_r       <= NOP_INST;
                    valid_r      <= 1'b0;
                    pend_valid_r <= 1'b0;
                end
                ACT_ADVANCE: begin
                    pc_r    <= pc_plus4_s;
                    inst_r  <= icache.ICACHE_rdata;
                    pcp4_r  <= pc_plus4_s;
                    valid_r <= 1'b1;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign icache.ICACHE_ren  = ~rst;
    assign icache.ICACHE_addr = pc_r[31:2];
    assign IF_ID_inst         = inst_r;
    assign IF_ID_pc_plus4     = pcp4_r;
    assign IF_ID_valid        = valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a cycle-level reference model pushes expected
// outputs per cycle and a monitor process pops and compares them.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard_stall = 1'b0, mem_stall = 1'b0;
    logic        PCSrc = 1'b0, IF_Flush = 1'b0, Jump = 1'b0, JumpR = 1'b0;
    logic [31:0] id_pc_plus4 = 32'h0, id_imm = 32'h0, id_rs_data = 32'h0;
    logic [25:0] id_jidx = 26'h0;
    logic        ic_stall = 1'b0;
    logic [31:0] IF_ID_inst, IF_ID_pc_plus4;
    logic        IF_ID_valid;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        ren;
        logic [29:0] addr;
        logic [31:0] inst;
        logic [31:0] pcp4;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: what the spec says PC / IF/ID / pending hold.
    logic [31:0] m_pc, m_inst, m_pcp4, m_pt;
    logic        m_valid, m_pv;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[13:0], 2'b01, ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    if_stage_if bus();
    assign bus.ICACHE_stall = ic_stall;
    assign bus.ICACHE_rdata = ic_stall ? 32'hDEAD_BEEF : mem_word(bus.ICACHE_addr);

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_stall   (hazard_stall),
        .mem_stall      (mem_stall),
        .PCSrc          (PCSrc),
        .IF_Flush       (IF_Flush),
        .Jump           (Jump),
        .JumpR          (JumpR),
        .id_pc_plus4    (id_pc_plus4),
        .id_imm         (id_imm),
        .id_jidx        (id_jidx),
        .id_rs_data     (id_rs_data),
        .icache         (bus),
        .IF_ID_inst     (IF_ID_inst),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_valid    (IF_ID_valid)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_inst = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_pv = 1'b0; m_pt = 32'h0;
    endtask

    function automatic exp_t snap(input logic ren);
        exp_t e;
        e.ren = ren; e.addr = m_pc[31:2]; e.inst = m_inst; e.pcp4 = m_pcp4; e.valid = m_valid;
        return e;
    endfunction

    // One clock of stimulus; the model applies the spec's first-match rules.
    task automatic cycle(input logic hz, input logic ms, input logic br, input logic fl,
                         input logic j, input logic jr, input logic ics,
                         input logic [31:0] ppc4, input logic [31:0] imm,
                         input logic [31:0] rs, input logic [25:0] jidx);
        logic [31:0] tgt;
        logic        redir;
        @(negedge clk);
        rst = 1'b0;
        hazard_stall = hz; mem_stall = ms; PCSrc = br; IF_Flush = fl; Jump = j; JumpR = jr;
        ic_stall = ics; id_pc_plus4 = ppc4; id_imm = imm; id_rs_data = rs; id_jidx = jidx;
        redir = br | j | jr;
        if (jr)      tgt = {rs[31:2], 2'b00};
        else if (j)  tgt = {ppc4[31:28], jidx, 2'b00};
        else if (br) tgt = ppc4 + imm * 32'd4;
        else         tgt = m_pc + 32'd4;
        if (ms || hz) begin
            // everything frozen
        end else if ((fl || redir) && ics) begin
            m_pv = redir; m_pt = tgt; m_inst = NOP_INST; m_valid = 1'b0;
        end else if (fl || redir) begin
            m_pc = tgt; m_inst = NOP_INST; m_valid = 1'b0; m_pv = 1'b0;
        end else if (ics) begin
            m_inst = NOP_INST; m_valid = 1'b0;
        end else if (m_pv) begin
            m_pc = m_pt; m_inst = NOP_INST; m_valid = 1'b0; m_pv = 1'b0;
        end else begin
            m_inst = mem_word(m_pc[31:2]); m_pcp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
        end
        exp_q.push_back(snap(1'b1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 26'h0);
    endtask

    // Asynchronous reset applied mid-cycle; checked immediately and at the next edge.
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_addr", {2'b00, bus.ICACHE_addr}, 32'h0);
        chk("async_rst_valid", {31'h0, IF_ID_valid}, 32'h0);
        model_reset();
        exp_q.push_back(snap(1'b0));
    endtask

    task automatic expect_addr(input string name, input logic [29:0] want);
        @(posedge clk);
        #2;
        chk(name, {2'b00, bus.ICACHE_addr}, {2'b00, want});
    endtask

    // Monitor: compare every presented cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ren", {31'h0, bus.ICACHE_ren}, {31'h0, e.ren});
                chk("addr", {2'b00, bus.ICACHE_addr}, {2'b00, e.addr});
                chk("if_id_inst", IF_ID_inst, e.inst);
                chk("if_id_pc_plus4", IF_ID_pc_plus4, e.pcp4);
                chk("if_id_valid", {31'h0, IF_ID_valid}, {31'h0, e.valid});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        model_reset();
        #2;
        chk("rst_ren", {31'h0, bus.ICACHE_ren}, 32'h0);
        chk("rst_addr", {2'b00, bus.ICACHE_addr}, 32'h0);
        chk("rst_inst", IF_ID_inst, NOP_INST);
        chk("rst_pc_plus4", IF_ID_pc_plus4, 32'h0);
        chk("rst_valid", {31'h0, IF_ID_valid}, 32'h0);

        idle(4);
        cycle(0, 0, 1, 0, 0, 0, 0, 32'h10, 32'hFFFF_FFFE, 32'h0, 26'h0);
        expect_addr("branch_target", 30'h2);
        idle(1);
        cycle(0, 0, 1, 0, 1, 0, 0, 32'h1000_0004, 32'h0000_0100, 32'h0, 26'h40);
        expect_addr("jump_wins", 30'h0400_0040);
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h203, 26'h0);
        expect_addr("jumpr_target", 30'h80);
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'hFFFF_FFFF, 26'h0);
        idle(1);
        expect_addr("pc_wrap", 30'h0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h80, 26'h0);
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 26'h0);
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 26'h0);
        idle(1);
        expect_addr("pending_redirect", 30'h20);
        idle(1);
        cycle(1, 0, 1, 0, 0, 0, 0, 32'h4000, 32'h8, 32'h0, 26'h0);
        cycle(1, 0, 1, 0, 0, 0, 0, 32'h4000, 32'h8, 32'h0, 26'h0);
        idle(2);
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h300, 26'h0);
        cycle(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 26'h0);
        cycle(0, 1, 1, 1, 0, 1, 1, 32'h40, 32'h4, 32'h500, 26'h0);
        do_reset();
        idle(3);

        for (int i = 0; i < 500; i++) begin
            r = $urandom;
            if ($urandom_range(0, 99) < 1) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
                      $urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 6,
                      $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 6,
                      $urandom_range(0, 99) < 25,
                      $urandom & 32'hFFFF_FFFC, {{16{r[15]}}, r[15:0]},
                      $urandom, r[31:6]);
            end
        end

        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC and drives the I-cache request.
- Resolves next-PC from the ID-stage control outputs (PCSrc, IF_Flush, Jump, JumpR) and owns the IF/ID pipeline register.
- Handles I-cache wait cycles, freezes from load-use hazards and D-cache stalls, and redirects that arrive while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard_stall  in  1  load-use stall from the hazard unit; holds PC and IF/ID.
- mem_stall  in  1  D-cache stall; freezes the whole pipeline.
- PCSrc  in  1  taken branch resolved in ID.
- IF_Flush  in  1  flush request from ID control.
- Jump  in  1  j/jal in ID.
- JumpR  in  1  jr/jalr in ID.
- id_pc_plus4  in  32  PC+4 of the instruction in ID.
- id_imm  in  32  sign-extended immediate of the instruction in ID.
- id_jidx  in  26  instr[25:0] of the instruction in ID.
- id_rs_data  in  32  forwarded rs value, used for jr/jalr.
- ICACHE_ren  out  1  fetch request.
- ICACHE_addr  out  30  word address, equal to PC[31:2].
- ICACHE_rdata  in  32  fetched instruction.
- ICACHE_stall  in  1  fetch not complete this cycle.
- IF_ID_inst  out  32  instruction to ID.
- IF_ID_pc_plus4  out  32  PC+4 to ID.
- IF_ID_valid  out  1  0 when IF/ID holds a bubble.

Behaviour:
- Reset (async) sets:
  - PC = RESET_PC.
  - IF_ID_inst = NOP_INST, IF_ID_pc_plus4 = 0, IF_ID_valid = 0.
  - pend_valid = 0, pend_target = 0.
- ICACHE_ren = 1 whenever rst = 0. ICACHE_addr = PC[31:2].
- ICACHE_addr must not change while ICACHE_stall = 1.
- redirect = PCSrc | Jump | JumpR. flush = IF_Flush | redirect.
- Target priority is JumpR > Jump > PCSrc:
  - JumpR: {id_rs_data[31:2], 2'b00}.
  - Jump: {id_pc_plus4[31:28], id_jidx, 2'b00}.
  - PCSrc: id_pc_plus4 + (id_imm << 2), modulo 2^32.
- Per-cycle priority (first match wins):
  1. mem_stall: hold PC, IF/ID and pending state; ignore redirect/flush, because the ID inputs are re-presented.
  2. hazard_stall: hold PC and IF/ID; ignore redirect, because the branch operands are not valid yet.
  3. flush with ICACHE_stall = 1: pend_valid <= redirect, pend_target <= target; PC held; IF/ID <= bubble. A later redirect overwrites pend_target.
  4. flush with ICACHE_stall = 0: PC <= target if redirect, else PC+4; IF/ID <= bubble; pend_valid <= 0.
  5. ICACHE_stall = 1 only: hold PC; IF/ID <= bubble, so ID drains and IF_ID_valid = 0.
  6. Fetch completes with pend_valid = 1: discard ICACHE_rdata (wrong path); PC <= pend_target; IF/ID <= bubble; pend_valid <= 0.
  7. Normal: PC <= PC+4; IF_ID_inst <= ICACHE_rdata; IF_ID_pc_plus4 <= PC+4; IF_ID_valid <= 1.
- Bubble means IF_ID_inst = NOP_INST, IF_ID_valid = 0. IF_ID_pc_plus4 keeps its previous value.
- Latency: one cycle from a completed fetch to IF/ID. A redirect costs exactly one bubble when the I-cache hits.
- PC wrap: PC+4 at 32'hFFFF_FFFC wraps to 0. There is no exception.
- Reset mid-stall: the pending redirect is lost and fetch restarts at RESET_PC.

Decomposition:
- Shared package (the pipeline constants package):
  - NOP_INST, RESET_PC.
  - Opcode/funct localparams.
  - A 2-bit next-PC select enum: SEQ, BR, J, JR.
- One sub-module, if_next_pc: purely combinational target/select computation.
- Register, pending and stall logic stays in if_stage.

Test Plan:
- Reset, then 4 hit cycles -> ICACHE_addr 0,1,2,3. IF/ID shows inst@0..2 with pc_plus4 4,8,12 and valid = 1.
- PCSrc = 1, id_pc_plus4 = 32'h10, id_imm = 32'hFFFF_FFFE -> next PC = 32'h08; one bubble (valid = 0); next fetch addr = 2.
- Jump = 1 and PCSrc = 1 in the same cycle, id_jidx = 26'h40, id_pc_plus4 = 32'h1000_0004 -> PC = 32'h1000_0100 (Jump wins). JumpR with id_rs_data = 32'h203 -> PC = 32'h200.
- ICACHE_stall held 3 cycles with a redirect to 32'h80 in cycle 1 -> addr stable, IF/ID bubbles, stale rdata discarded at stall release, next addr = 32'h20.
- hazard_stall for 2 cycles with PCSrc = 1 -> PC and IF/ID unchanged, redirect ignored; PC advances by 4 after release.
- mem_stall asserted together with ICACHE_stall, then rst pulsed mid-stall -> all outputs hold during the stall; reset forces PC = 0, valid = 0, pending cleared.
